alarm_buzzer_driver: RTL and testbench
======================================

# alarm_buzzer_driver

Downstream consumer of the alarm-match latch output (`z`). Converts the steady "alarm sounding" level into an audible beep cadence (gated square-wave tone) for the piezo buzzer. Adds snooze and an auto-silence timeout so the buzzer stops even while the alarm switch keeps the match latch asserted.

## Interface
Parameters:
- `TONE_DIV`, 25000: clk cycles per tone half-period (≥2).
- `BEEP_ON_TICKS`, 5: ticks buzzer sounds per cadence cycle (≥1).
- `BEEP_OFF_TICKS`, 5: ticks silent per cadence cycle (≥1).
- `SNOOZE_TICKS`, 3000: ticks spent snoozed (≥1).
- `TIMEOUT_TICKS`, 600: beeping ticks before auto-silence (≥1).

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `alarm_in`  in  1  alarm level from the match latch (`z`).
- `tick`  in  1  one-`clk` strobe from the clock divider, nominally 10 Hz.
- `snooze`  in  1  snooze button level; already debounced and synchronous to `clk`.
- `buzzer`  out  1  tone to piezo driver.
- `active`  out  1  high while beeping (BEEP_ON or BEEP_OFF).
- `snoozing`  out  1  high while in SNOOZE.

## Operation
- States: IDLE, BEEP_ON, BEEP_OFF, SNOOZE, SILENCED. Reset → IDLE. All counters clear to 0, `snooze_q` clears to 0, and all outputs are 0.
- Snooze event: `snooze & ~snooze_q`, a rising edge registered every cycle.
- Transition priority, highest first:
  1. `alarm_in`=0 → IDLE, from any state.
  2. Timeout: in BEEP_ON/BEEP_OFF, a tick with `timeout_cnt`==TIMEOUT_TICKS-1 → SILENCED.
  3. Snooze event in BEEP_ON/BEEP_OFF → SNOOZE.
  4. Cadence or snooze expiry.
- IDLE: `alarm_in`=1 → BEEP_ON. Clears `timeout_cnt`.
- BEEP_ON: each tick increments `phase_cnt`. A tick at BEEP_ON_TICKS-1 → BEEP_OFF.
- BEEP_OFF: a tick at BEEP_OFF_TICKS-1 → BEEP_ON.
- SNOOZE: each tick increments `phase_cnt`. A tick at SNOOZE_TICKS-1 → BEEP_ON.
- SILENCED: held until `alarm_in`=0.
- `phase_cnt` clears on every state change. A tick in the same cycle as a state change is not counted in the new state.
- `timeout_cnt` increments on ticks in BEEP_ON/BEEP_OFF only. It holds through SNOOZE and clears only in IDLE, so the timeout is per alarm session.
- Tone: `tone_cnt` counts 0..TONE_DIV-1 in BEEP_ON and toggles `tone` at wrap. `tone_cnt` and `tone` are cleared whenever the block is not in BEEP_ON.
- Outputs are Moore and decoded from registered state: `buzzer` = `tone` in BEEP_ON, else 0.
- Counter widths: `$clog2` of the respective parameter, minimum 1.

## Timing
- `alarm_in` rising at edge N → BEEP_ON and `active`=1 after edge N+1.
- First `buzzer` high occurs TONE_DIV cycles after BEEP_ON entry. Tone period is 2·TONE_DIV.
- `alarm_in` falling → IDLE and all outputs 0 one cycle later, whatever the state.
- Snooze edge → `snoozing`=1 and `buzzer`=0 one cycle later.
- Reset asserted mid-session → IDLE on the next edge. `alarm_in` still high after reset release restarts BEEP_ON with a fresh timeout.
- A snooze edge coinciding with a timeout tick → SILENCED.

## Configuration
- `ALARM_BUZZER_SNOOZE_EN` defined: snooze behaves as described.
- `ALARM_BUZZER_SNOOZE_EN` undefined:
  - `snooze` input is ignored.
  - SNOOZE state and `snooze_q` are not built.
  - `snoozing` is tied to 0.
  - All other behaviour is unchanged.

## Structure
- Shared package `alarm_pkg` holds:
  - typedef `buzz_state_t` (enum of the five states);
  - default parameter constants.
- Sub-module `alarm_tone_gen` holds the TONE_DIV divider with an enable/clear input. The top module holds the FSM and tick counters.

## Test plan
Bench parameters: TONE_DIV=4, BEEP_ON_TICKS=2, BEEP_OFF_TICKS=2, SNOOZE_TICKS=5, TIMEOUT_TICKS=12, tick every 20 cycles.
- Reset held 3 cycles with `alarm_in`=1 → all outputs 0. BEEP_ON entered 1 cycle after release.
- `alarm_in`=1 steady → `buzzer` toggles every 4 cycles for 2 ticks, then silent for 2 ticks, repeating. `active`=1 throughout.
- Snooze pulse in BEEP_OFF → `snoozing`=1 next cycle. After 5 ticks, BEEP_ON with `snoozing`=0.
- `alarm_in` held 1, no snooze → SILENCED after 12 beeping ticks with `active`=0. `alarm_in` then 0 → IDLE. `alarm_in` then 1 → beeping restarts.
- `alarm_in` dropped in SNOOZE and in BEEP_ON → IDLE next cycle, `buzzer`=0.
- Snooze pulse in the same cycle as the 12th beeping tick → SILENCED, not SNOOZE.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm buzzer driver and its tone generator.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEEP_ON,
    ST_BEEP_OFF,
    ST_SNOOZE,
    ST_SILENCED
  } buzz_state_t;

  localparam int DEF_TONE_DIV       = 25000;
  localparam int DEF_BEEP_ON_TICKS  = 5;
  localparam int DEF_BEEP_OFF_TICKS = 5;
  localparam int DEF_SNOOZE_TICKS   = 3000;
  localparam int DEF_TIMEOUT_TICKS  = 600;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Square-wave tone: toggles every TONE_DIV cycles while enabled; counter and tone
// are held cleared whenever the enable is low, so each burst starts from a known phase.
module alarm_tone_gen
  import alarm_pkg::*;
#(
  parameter int TONE_DIV = DEF_TONE_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tone_o
);

  localparam int            TW   = cnt_w(TONE_DIV);
  localparam logic [TW-1:0] LAST = TW'(TONE_DIV - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          tone_q, tone_d;

  always_comb begin
    cnt_d  = '0;
    tone_d = 1'b0;
    if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d  = cnt_q + TW'(1);
        tone_d = tone_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone_o = tone_q;

endmodule

// File: rtl/alarm_buzzer_driver.sv
// Turns the alarm-match level into a beep cadence with snooze and auto-silence timeout.
// Snooze support is built only when ALARM_BUZZER_SNOOZE_EN is defined.
module alarm_buzzer_driver
  import alarm_pkg::*;
#(
  parameter int TONE_DIV       = DEF_TONE_DIV,
  parameter int BEEP_ON_TICKS  = DEF_BEEP_ON_TICKS,
  parameter int BEEP_OFF_TICKS = DEF_BEEP_OFF_TICKS,
  parameter int SNOOZE_TICKS   = DEF_SNOOZE_TICKS,
  parameter int TIMEOUT_TICKS  = DEF_TIMEOUT_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic alarm_in,
  input  logic tick,
  input  logic snooze,
  output logic buzzer,
  output logic active,
  output logic snoozing
);

  localparam int            PW       = cnt_w(max3(BEEP_ON_TICKS, BEEP_OFF_TICKS, SNOOZE_TICKS));
  localparam int            TW       = cnt_w(TIMEOUT_TICKS);
  localparam logic [PW-1:0] ON_LAST  = PW'(BEEP_ON_TICKS - 1);
  localparam logic [PW-1:0] OFF_LAST = PW'(BEEP_OFF_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);

  buzz_state_t   state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic          active_q, snoozing_q;
  logic          beeping;
  logic          snz_evt;
  logic          tone;

`ifdef ALARM_BUZZER_SNOOZE_EN
  localparam logic [PW-1:0] SNZ_LAST = PW'(SNOOZE_TICKS - 1);
  logic snooze_q;

  assign snz_evt = snooze & ~snooze_q;

  always_ff @(posedge clk) begin
    if (reset) snooze_q <= 1'b0;
    else       snooze_q <= snooze;
  end
`else
  logic unused_snooze;

  assign snz_evt       = 1'b0;
  assign unused_snooze = snooze;
`endif

  // Alarm release beats timeout, timeout beats snooze, snooze beats cadence.
  always_comb begin
    state_d = state_q;
    beeping = (state_q == ST_BEEP_ON) || (state_q == ST_BEEP_OFF);
    if (!alarm_in) begin
      state_d = ST_IDLE;
    end else if (beeping && tick && (timeout_q == TO_LAST)) begin
      state_d = ST_SILENCED;
    end else if (beeping && snz_evt) begin
      state_d = ST_SNOOZE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_BEEP_ON;
        ST_BEEP_ON:  if (tick && (phase_q == ON_LAST))  state_d = ST_BEEP_OFF;
        ST_BEEP_OFF: if (tick && (phase_q == OFF_LAST)) state_d = ST_BEEP_ON;
`ifdef ALARM_BUZZER_SNOOZE_EN
        ST_SNOOZE:   if (tick && (phase_q == SNZ_LAST)) state_d = ST_BEEP_ON;
`endif
        default:     state_d = state_q;
      endcase
    end

    if (state_d != state_q)
      phase_d = '0;
    else if (tick && (beeping || (state_q == ST_SNOOZE)))
      phase_d = phase_q + PW'(1);
    else
      phase_d = phase_q;

    // Held through snooze so the timeout spans the whole alarm session.
    if (state_q == ST_IDLE)
      timeout_d = '0;
    else if (tick && beeping && (timeout_q != TO_LAST))
      timeout_d = timeout_q + TW'(1);
    else
      timeout_d = timeout_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      timeout_q  <= '0;
      active_q   <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      timeout_q  <= timeout_d;
      active_q   <= (state_d == ST_BEEP_ON) || (state_d == ST_BEEP_OFF);
      snoozing_q <= (state_d == ST_SNOOZE);
    end
  end

  alarm_tone_gen #(
    .TONE_DIV (TONE_DIV)
  ) u_tone (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q == ST_BEEP_ON),
    .tone_o (tone)
  );

  assign buzzer   = tone & (state_q == ST_BEEP_ON);
  assign active   = active_q;
  assign snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_buzzer_driver.sv
// Bench for alarm_buzzer_driver: vector table, directed corner sequences, random run vs model.
`timescale 1ns/1ps
module tb_alarm_buzzer_driver;

  localparam int TD = 4, ON = 2, OFF = 2, SN = 5, TO = 12, TPER = 20, P = ON + OFF;
`ifdef ALARM_BUZZER_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_BEEP = 1, M_SNZ = 2, M_SIL = 3;

  logic clk = 1'b0, reset = 1'b1, alarm_in = 1'b0, tick = 1'b0, snooze = 1'b0;
  logic buzzer, active, snoozing;

  alarm_buzzer_driver #(
    .TONE_DIV(TD), .BEEP_ON_TICKS(ON), .BEEP_OFF_TICKS(OFF),
    .SNOOZE_TICKS(SN), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .reset(reset), .alarm_in(alarm_in), .tick(tick), .snooze(snooze),
    .buzzer(buzzer), .active(active), .snoozing(snoozing)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, tcnt = 0;

  // Session-level model: ticks into the cadence, beeping ticks used, snooze ticks, cycles into an ON burst.
  int m_mode = M_IDLE, m_k = 0, m_beeps = 0, m_sn = 0, m_oncyc = 0;
  bit m_sq = 1'b0;

  task automatic model_step();
    bit evt;
    if (reset) begin
      m_mode = M_IDLE; m_k = 0; m_beeps = 0; m_sn = 0; m_oncyc = 0; m_sq = 1'b0;
    end else begin
      evt  = SNZ_EN && snooze && !m_sq;
      m_sq = SNZ_EN ? snooze : 1'b0;
      if (!alarm_in) begin
        m_mode = M_IDLE; m_beeps = 0;
      end else begin
        case (m_mode)
          M_IDLE: begin m_mode = M_BEEP; m_k = 0; m_oncyc = 0; m_beeps = 0; end
          M_BEEP: begin
            if (tick) m_beeps++;
            if (tick && m_beeps == TO) m_mode = M_SIL;
            else if (evt) begin m_mode = M_SNZ; m_sn = 0; end
            else begin
              if (tick) m_k++;
              if (tick && (m_k % P) == 0) m_oncyc = 0;
              else m_oncyc++;
            end
          end
          M_SNZ: if (tick) begin
            m_sn++;
            if (m_sn == SN) begin m_mode = M_BEEP; m_k = 0; m_oncyc = 0; end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit a, input bit s, input bit t);
    logic e_buz;
    reset = r; alarm_in = a; snooze = s; tick = t;
    model_step();
    @(posedge clk);
    #1;
    e_buz = (m_mode == M_BEEP) && ((m_k % P) < ON) && (((m_oncyc / TD) % 2) == 1);
    chk("model_buzzer", buzzer, e_buz);
    chk("model_active", active, m_mode == M_BEEP);
    chk("model_snoozing", snoozing, m_mode == M_SNZ);
  endtask

  task automatic run(input int n, input bit a);
    for (int i = 0; i < n; i++) begin
      tcnt++;
      step(1'b0, a, 1'b0, (tcnt % TPER) == 0);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    tcnt = 0;
  endtask

  typedef struct {
    bit r; bit a; bit s; bit t;
    bit eb; bit ea; bit es;
  } vec_t;
  localparam int NV = 19;
  vec_t tbl[NV];

  initial begin
    bit rr, ra, rs, rt;

    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 1, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 1, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, 1, 1, 0};
    tbl[8]  = '{0, 1, 0, 0, 1, 1, 0};
    tbl[9]  = '{0, 1, 0, 0, 1, 1, 0};
    tbl[10] = '{0, 1, 0, 0, 1, 1, 0};
    tbl[11] = '{0, 1, 0, 0, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 0, 1, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 0, 0, 1, 0};
    tbl[16] = '{0, 1, 1, 0, 0, !SNZ_EN, SNZ_EN};
    tbl[17] = '{0, 1, 1, 0, 0, !SNZ_EN, SNZ_EN};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].r, tbl[i].a, tbl[i].s, tbl[i].t);
      chk($sformatf("vec%0d_buzzer", i), buzzer, tbl[i].eb);
      chk($sformatf("vec%0d_active", i), active, tbl[i].ea);
      chk($sformatf("vec%0d_snoozing", i), snoozing, tbl[i].es);
    end

    // Snooze pressed during BEEP_OFF, then five snooze ticks back to BEEP_ON, then alarm drop.
    do_reset();
    run(50, 1'b1);
    chk("off_active", active, 1'b1);
    chk("off_buzzer", buzzer, 1'b0);
    tcnt++; step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("snz_enter_snoozing", snoozing, SNZ_EN);
    chk("snz_enter_buzzer", buzzer, 1'b0);
    run(88, 1'b1);
    chk("snz_hold_snoozing", snoozing, SNZ_EN);
    run(1, 1'b1);
    chk("snz_exit_snoozing", snoozing, 1'b0);
    chk("snz_exit_active", active, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_beep_active", active, 1'b0);
    chk("drop_beep_buzzer", buzzer, 1'b0);

    // Alarm dropped while snoozed.
    do_reset();
    run(50, 1'b1);
    tcnt++; step(1'b0, 1'b1, 1'b1, 1'b0);
    run(10, 1'b1);
    chk("pre_drop_snoozing", snoozing, SNZ_EN);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_snz_snoozing", snoozing, 1'b0);
    chk("drop_snz_active", active, 1'b0);
    chk("drop_snz_buzzer", buzzer, 1'b0);

    // Auto-silence after 12 beeping ticks, release, restart.
    do_reset();
    run(239, 1'b1);
    chk("timeout_pre_active", active, 1'b1);
    run(1, 1'b1);
    chk("timeout_active", active, 1'b0);
    chk("timeout_buzzer", buzzer, 1'b0);
    run(30, 1'b1);
    chk("silenced_hold_active", active, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("silenced_release_active", active, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("restart_active", active, 1'b1);

    // Snooze edge on the 12th beeping tick: timeout wins.
    do_reset();
    run(239, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("coinc_active", active, 1'b0);
    chk("coinc_snoozing", snoozing, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("coinc_hold_snoozing", snoozing, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("midreset_active", active, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_reset_active", active, 1'b1);

    // Random run against the model.
    do_reset();
    ra = 1'b1; rs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom % 400) == 0;
      if (($urandom % 150) == 0) ra = ~ra;
      if (($urandom % 25) == 0) rs = ~rs;
      rt = ($urandom % 8) == 0;
      step(rr, ra, rs, rt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
